// File: rtl/data_cache_if.sv
// Bus bundle for the L1 data cache: memory-stage request/response, main-memory
// handshake and the load hit/miss statistics. The cache connects through the
// slave modport. The pipeline/memory side (or a testbench) uses master.
interface data_cache_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  // memory-stage request and response
  logic                    req_valid;
  logic                    req_write;
  logic [2:0]              req_ctrl;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    stall;
  // main data memory handshake
  logic                    mem_req;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    mem_ready;
  // statistics
  logic [31:0]             hit_count;
  logic [31:0]             miss_count;

  modport slave (
    input  req_valid, req_write, req_ctrl, req_addr, req_wdata, mem_rdata, mem_ready,
    output rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be, hit_count, miss_count
  );

  modport master (
    output req_valid, req_write, req_ctrl, req_addr, req_wdata, mem_rdata, mem_ready,
    input  rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be, hit_count, miss_count
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache.
// Load hits answer in the same cycle. Load misses refill a whole line word by word.
// Stores always write through to memory and update the cached copy only on a hit.
// The stall output holds the pipeline while a refill or write-through is outstanding.
module data_cache #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SETS           = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic         clk,
  input  logic         rst,
  data_cache_if.slave  bus
);
  localparam int IDX_W   = $clog2(SETS);
  localparam int OFF_W   = $clog2(WORDS_PER_LINE);
  localparam int LINE_LSB = 2 + OFF_W;
  localparam int TAG_LSB = LINE_LSB + IDX_W;
  localparam int TAG_W   = ADDR_WIDTH - TAG_LSB;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                       state_q, state_d;
  logic [OFF_W-1:0]             ctr_q, ctr_d;
  logic [ADDR_WIDTH-1:LINE_LSB] base_q, base_d;
  logic [SETS-1:0]              valid_q;
  logic [TAG_W-1:0]             tag_q  [SETS];
  logic [DATA_WIDTH-1:0]        data_q [SETS*WORDS_PER_LINE];
  logic [31:0]                  hit_q, miss_q;

  // request decode
  logic [IDX_W-1:0]      req_idx_s;
  logic [OFF_W-1:0]      req_off_s;
  logic [TAG_W-1:0]      req_tag_s;
  logic                  hit_s;
  logic [DATA_WIDTH-1:0] word_s;
  logic [IDX_W-1:0]      fill_idx_s;
  logic [TAG_W-1:0]      fill_tag_s;

  assign req_idx_s  = bus.req_addr[LINE_LSB +: IDX_W];
  assign req_off_s  = bus.req_addr[2 +: OFF_W];
  assign req_tag_s  = bus.req_addr[TAG_LSB +: TAG_W];
  assign hit_s      = valid_q[req_idx_s] && (tag_q[req_idx_s] == req_tag_s);
  assign word_s     = data_q[{req_idx_s, req_off_s}];
  assign fill_idx_s = base_q[LINE_LSB +: IDX_W];
  assign fill_tag_s = base_q[TAG_LSB +: TAG_W];

  // Select the addressed byte/half of a word and sign- or zero-extend it.
  function automatic logic [31:0] ext_load(input logic [31:0] w, input logic [2:0] ctrl,
                                           input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*lane +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (ctrl)
      3'b000:  ext_load = {{24{b[7]}}, b};
      3'b001:  ext_load = {{16{h[15]}}, h};
      3'b100:  ext_load = {24'd0, b};
      3'b101:  ext_load = {16'd0, h};
      default: ext_load = w;
    endcase
  endfunction

  // store lane placement
  logic [3:0]            st_be_s;
  logic [DATA_WIDTH-1:0] st_data_s;

  // Place store data on its byte lanes and build the matching byte enables.
  always_comb begin
    st_be_s   = 4'b1111;
    st_data_s = bus.req_wdata;
    case (bus.req_ctrl)
      3'b000: begin
        st_be_s   = 4'b0001 << bus.req_addr[1:0];
        st_data_s = {24'd0, bus.req_wdata[7:0]} << {bus.req_addr[1:0], 3'b000};
      end
      3'b001: begin
        st_be_s   = 4'b0011 << {bus.req_addr[1], 1'b0};
        st_data_s = {16'd0, bus.req_wdata[15:0]} << {bus.req_addr[1], 4'b0000};
      end
      default: begin
        st_be_s   = 4'b1111;
        st_data_s = bus.req_wdata;
      end
    endcase
  end

  // FSM outputs and strobes
  logic                  stall_s, mem_req_s, mem_we_s;
  logic [ADDR_WIDTH-1:0] mem_addr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s, rdata_s;
  logic [3:0]            mem_be_s;
  logic                  load_hit_s, load_miss_s, store_hit_s, refill_wr_s, refill_last_s;

  // Next-state logic, memory handshake outputs, load data and the state-update strobes.
  always_comb begin
    state_d       = state_q;
    ctr_d         = ctr_q;
    base_d        = base_q;
    stall_s       = 1'b0;
    rdata_s       = '0;
    mem_req_s     = 1'b0;
    mem_we_s      = 1'b0;
    mem_addr_s    = '0;
    mem_wdata_s   = '0;
    mem_be_s      = 4'b0000;
    load_hit_s    = 1'b0;
    load_miss_s   = 1'b0;
    store_hit_s   = 1'b0;
    refill_wr_s   = 1'b0;
    refill_last_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!bus.req_valid) begin
          state_d = S_IDLE;
        end else if (bus.req_write) begin
          stall_s     = 1'b1;
          store_hit_s = hit_s;
          state_d     = S_WRITE;
        end else if (hit_s) begin
          rdata_s    = ext_load(word_s, bus.req_ctrl, bus.req_addr[1:0]);
          load_hit_s = 1'b1;
        end else begin
          stall_s     = 1'b1;
          load_miss_s = 1'b1;
          ctr_d       = '0;
          base_d      = bus.req_addr[ADDR_WIDTH-1:LINE_LSB];
          state_d     = S_REFILL;
        end
      end
      S_REFILL: begin
        stall_s    = 1'b1;
        mem_req_s  = 1'b1;
        mem_addr_s = {base_q, ctr_q, 2'b00};
        if (bus.mem_ready) begin
          refill_wr_s = 1'b1;
          ctr_d       = ctr_q + OFF_W'(1);
          if (ctr_q == {OFF_W{1'b1}}) begin
            refill_last_s = 1'b1;
            state_d       = S_DONE;
          end else begin
            state_d = S_REFILL;
          end
        end else begin
          state_d = S_REFILL;
        end
      end
      S_WRITE: begin
        stall_s     = 1'b1;
        mem_req_s   = 1'b1;
        mem_we_s    = 1'b1;
        mem_addr_s  = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
        mem_wdata_s = st_data_s;
        mem_be_s    = st_be_s;
        if (bus.mem_ready) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_DONE: begin
        if (bus.req_write) begin
          rdata_s = '0;
        end else begin
          rdata_s = ext_load(word_s, bus.req_ctrl, bus.req_addr[1:0]);
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, refill counter, line base, valid bits and statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ctr_q   <= '0;
      base_q  <= '0;
      valid_q <= '0;
      hit_q   <= 32'd0;
      miss_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      base_q  <= base_d;
      if (refill_last_s) begin
        valid_q[fill_idx_s] <= 1'b1;
      end
      if (load_hit_s) begin
        hit_q <= hit_q + 32'd1;
      end
      if (load_miss_s) begin
        miss_q <= miss_q + 32'd1;
      end
    end
  end

  // Line storage: refill words from memory, merge store-hit bytes, record tag on last word.
  always_ff @(posedge clk) begin
    if (!rst && refill_wr_s) begin
      data_q[{fill_idx_s, ctr_q}] <= bus.mem_rdata;
    end else if (!rst && store_hit_s) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be_s[b]) begin
          data_q[{req_idx_s, req_off_s}][8*b +: 8] <= st_data_s[8*b +: 8];
        end
      end
    end
    if (!rst && refill_last_s) begin
      tag_q[fill_idx_s] <= fill_tag_s;
    end
  end

  assign bus.stall      = stall_s;
  assign bus.rdata      = rdata_s;
  assign bus.mem_req    = mem_req_s;
  assign bus.mem_we     = mem_we_s;
  assign bus.mem_addr   = mem_addr_s;
  assign bus.mem_wdata  = mem_wdata_s;
  assign bus.mem_be     = mem_be_s;
  assign bus.hit_count  = hit_q;
  assign bus.miss_count = miss_q;
endmodule

// File: tb/tb_data_cache.sv
// Testbench for data_cache. Reference model: memory is a word map, and the cache is
// tracked only as "which line address occupies each set". Because the cache is
// write-through, any load returns the memory word, so expected load data always
// comes from the memory map.
module tb_data_cache;
  logic clk;
  logic rst;
  data_cache_if bus ();

  data_cache dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  // reference model state
  logic [31:0] mem_m [int unsigned];
  logic        res_v [64];
  logic [27:0] res_line [64];
  int unsigned hits_m = 0;
  int unsigned misses_m = 0;

  logic [2:0] ld_ctrls [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  logic [2:0] st_ctrls [3] = '{3'b000, 3'b001, 3'b010};

  logic [31:0] rd;
  int          nst;
  logic        fst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    int unsigned wi;
    wi = a >> 2;
    if (mem_m.exists(wi)) return mem_m[wi];
    return (wi * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] ctrl,
                                             input logic [31:0] a);
    logic [31:0] v;
    int unsigned lo;
    lo = a % 4;
    case (ctrl)
      3'b000, 3'b100: begin
        v = (w >> (8 * lo)) & 32'hFF;
        if (ctrl == 3'b000 && v >= 32'h80) v = v + 32'hFFFFFF00;
      end
      3'b001, 3'b101: begin
        v = (w >> (16 * (lo / 2))) & 32'hFFFF;
        if (ctrl == 3'b001 && v >= 32'h8000) v = v + 32'hFFFF0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 64; s++) res_v[s] = 1'b0;
    hits_m = 0;
    misses_m = 0;
  endtask

  // One complete access; drives the request right after a rising edge and returns
  // the observed final rdata, the number of stalled cycles and whether the first
  // cycle stalled.
  task automatic access(input logic wr, input logic [2:0] ctrl, input logic [31:0] addr,
                        input logic [31:0] wd, input int maxwait,
                        output logic [31:0] rd_o, output int nstall_o, output logic fst_o);
    int          set_i;
    logic        hit_m;
    logic [31:0] base, w, exp_be, exp_wd, exp_rd;
    int          waits;
    int unsigned lo;
    set_i = (addr >> 4) % 64;
    hit_m = res_v[set_i] && (res_line[set_i] == addr[31:4]);
    lo = addr % 4;
    nstall_o = 0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_ctrl  = ctrl;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(negedge clk);
    fst_o = bus.stall;
    if (bus.stall) nstall_o++;
    if (!wr && hit_m) begin
      exp_rd = model_load(rd_mem(addr), ctrl, addr);
      chk("hit_stall", bus.stall, 32'd0);
      chk("hit_rdata", bus.rdata, exp_rd);
      chk("hit_mem_req", bus.mem_req, 32'd0);
      rd_o = bus.rdata;
      hits_m++;
      @(posedge clk); #1;
    end else begin
      chk("first_stall", bus.stall, 32'd1);
      chk("first_mem_req", bus.mem_req, 32'd0);
      @(posedge clk); #1;
      if (!wr) begin
        misses_m++;
        base = addr & ~32'hF;
        for (int k = 0; k < 4; k++) begin
          waits = $urandom_range(0, maxwait);
          for (int c = 0; c <= waits; c++) begin
            @(negedge clk);
            if (bus.stall) nstall_o++;
            chk("refill_mem_req", bus.mem_req, 32'd1);
            chk("refill_mem_we", bus.mem_we, 32'd0);
            chk("refill_mem_addr", bus.mem_addr, base + 32'd4 * k);
            chk("refill_stall", bus.stall, 32'd1);
            if (c == waits) begin
              bus.mem_ready = 1'b1;
              bus.mem_rdata = rd_mem(base + 32'd4 * k);
            end
            @(posedge clk); #1;
            bus.mem_ready = 1'b0;
            bus.mem_rdata = $urandom;
          end
        end
        res_v[set_i] = 1'b1;
        res_line[set_i] = addr[31:4];
      end else begin
        case (ctrl)
          3'b000: begin exp_be = 32'd1 << lo; exp_wd = (wd & 32'hFF) << (8 * lo); end
          3'b001: begin exp_be = 32'd3 << (2 * (lo / 2)); exp_wd = (wd & 32'hFFFF) << (16 * (lo / 2)); end
          default: begin exp_be = 32'hF; exp_wd = wd; end
        endcase
        waits = $urandom_range(0, maxwait);
        for (int c = 0; c <= waits; c++) begin
          @(negedge clk);
          if (bus.stall) nstall_o++;
          chk("write_mem_req", bus.mem_req, 32'd1);
          chk("write_mem_we", bus.mem_we, 32'd1);
          chk("write_mem_addr", bus.mem_addr, addr & ~32'h3);
          chk("write_mem_be", bus.mem_be, exp_be);
          chk("write_mem_wdata", bus.mem_wdata, exp_wd);
          chk("write_stall", bus.stall, 32'd1);
          if (c == waits) bus.mem_ready = 1'b1;
          @(posedge clk); #1;
          bus.mem_ready = 1'b0;
        end
        w = rd_mem(addr);
        for (int b = 0; b < 4; b++) if (exp_be[b]) w[8*b +: 8] = exp_wd[8*b +: 8];
        mem_m[addr >> 2] = w;
      end
      @(negedge clk);
      exp_rd = wr ? 32'd0 : model_load(rd_mem(addr), ctrl, addr);
      chk("done_stall", bus.stall, 32'd0);
      chk("done_mem_req", bus.mem_req, 32'd0);
      chk("done_rdata", bus.rdata, exp_rd);
      rd_o = bus.rdata;
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    chk("hit_count", bus.hit_count, hits_m);
    chk("miss_count", bus.miss_count, misses_m);
  endtask

  initial begin
    logic        wr;
    logic [2:0]  ctrl;
    logic [31:0] addr, line;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_ctrl  = 3'b010;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;
    bus.mem_rdata = 32'd0;
    bus.mem_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_stall", bus.stall, 32'd0);
    chk("rst_mem_req", bus.mem_req, 32'd0);
    chk("rst_mem_we", bus.mem_we, 32'd0);
    chk("rst_mem_be", bus.mem_be, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_hit_count", bus.hit_count, 32'd0);
    chk("rst_miss_count", bus.miss_count, 32'd0);
    @(posedge clk); #1;

    // first load miss with memory ready every cycle
    mem_m[32'h100 >> 2] = 32'hDEADBEEF;
    access(1'b0, 3'b010, 32'h100, 32'd0, 0, rd, nst, fst);
    chk("t1_rdata", rd, 32'hDEADBEEF);
    chk("t1_stall_cycles", nst, 32'd5);
    chk("t1_miss_count", bus.miss_count, 32'd1);

    // hits on the refilled line
    access(1'b0, 3'b010, 32'h100, 32'd0, 0, rd, nst, fst);
    chk("t2_hit_a", fst, 32'd0);
    chk("t2_rdata_a", rd, 32'hDEADBEEF);
    access(1'b0, 3'b010, 32'h104, 32'd0, 0, rd, nst, fst);
    chk("t2_hit_b", fst, 32'd0);
    chk("t2_hit_count", bus.hit_count, 32'd2);

    // byte store on the cached line, then byte loads
    access(1'b1, 3'b000, 32'h101, 32'h000000AA, 1, rd, nst, fst);
    access(1'b0, 3'b100, 32'h101, 32'd0, 0, rd, nst, fst);
    chk("t3_lbu_hit", fst, 32'd0);
    chk("t3_lbu", rd, 32'h000000AA);
    access(1'b0, 3'b000, 32'h101, 32'd0, 0, rd, nst, fst);
    chk("t3_lb", rd, 32'hFFFFFFAA);

    // store miss does not allocate
    access(1'b1, 3'b010, 32'h2000, 32'h12345678, 1, rd, nst, fst);
    access(1'b0, 3'b010, 32'h2000, 32'd0, 1, rd, nst, fst);
    chk("t4_load_miss", fst, 32'd1);
    chk("t4_rdata", rd, 32'h12345678);

    // conflicting lines in the same set
    access(1'b0, 3'b010, 32'h500, 32'd0, 1, rd, nst, fst);
    chk("t5_miss_500", fst, 32'd1);
    access(1'b0, 3'b010, 32'h100, 32'd0, 1, rd, nst, fst);
    chk("t5_miss_100", fst, 32'd1);
    access(1'b0, 3'b010, 32'h500, 32'd0, 1, rd, nst, fst);
    chk("t5_miss_500b", fst, 32'd1);

    // randomized traffic over a few conflicting sets
    for (int i = 0; i < 200; i++) begin
      line = ($urandom_range(0, 3) << 6) | $urandom_range(0, 3);
      addr = (line << 4) | $urandom_range(0, 15);
      wr   = ($urandom_range(0, 2) == 0);
      ctrl = wr ? st_ctrls[$urandom_range(0, 2)] : ld_ctrls[$urandom_range(0, 4)];
      access(wr, ctrl, addr, $urandom, 2, rd, nst, fst);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        chk("idle_stall", bus.stall, 32'd0);
        chk("idle_rdata", bus.rdata, 32'd0);
        chk("idle_mem_req", bus.mem_req, 32'd0);
        @(posedge clk); #1;
      end
    end

    // reset during the second refill word
    access(1'b0, 3'b010, 32'h100, 32'd0, 0, rd, nst, fst);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_ctrl  = 3'b010;
    bus.req_addr  = 32'h7300;
    @(negedge clk);
    chk("t6_first_stall", bus.stall, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = rd_mem(32'h7300);
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_word1_mem_addr", bus.mem_addr, 32'h7304);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    model_reset();
    @(negedge clk);
    chk("t6_mem_req", bus.mem_req, 32'd0);
    chk("t6_stall", bus.stall, 32'd0);
    chk("t6_miss_count", bus.miss_count, 32'd0);
    chk("t6_hit_count", bus.hit_count, 32'd0);
    @(posedge clk); #1;
    access(1'b0, 3'b010, 32'h100, 32'd0, 1, rd, nst, fst);
    chk("t6_reload_miss", fst, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
